// File: rtl/ysyx_041514_ifu_responder.sv
// Instruction-fetch responder: one-doubleword line buffer in front of a single
// outstanding AXI-style read, with a sticky error entry for faulting fetches.
module ysyx_041514_ifu_responder (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] inst_addr_i,
   input  logic        inst_req_i,
   input  logic        flush_i,
   input  logic        fence_i_i,
   output logic        if_rdata_valid_o,
   output logic [63:0] if_rdata_o,
   output logic        if_access_fault_o,
   output logic        mem_ar_valid_o,
   input  logic        mem_ar_ready_i,
   output logic [63:0] mem_ar_addr_o,
   input  logic        mem_r_valid_i,
   output logic        mem_r_ready_o,
   input  logic [63:0] mem_r_data_i,
   input  logic [1:0]  mem_r_resp_i
);

   localparam int unsigned XLEN     = 64;
   localparam int unsigned INST_LEN = 32;
   localparam int unsigned TAG_W    = XLEN - 3;
   localparam logic [INST_LEN-1:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

   state_t             state, state_nxt;
   logic               buf_v, buf_v_nxt;
   logic [TAG_W-1:0]   buf_tag, buf_tag_nxt;
   logic [XLEN-1:0]    buf_data, buf_data_nxt;
   logic               err_v, err_v_nxt;
   logic [TAG_W-1:0]   err_tag, err_tag_nxt;
   logic [TAG_W-1:0]   req_tag, req_tag_nxt;
   logic               drop, drop_nxt;

   logic [TAG_W-1:0]   pc_tag;
   logic               hit, err_hit;
   logic [INST_LEN-1:0] hit_word;
   logic               unused_addr_lsb;

   assign pc_tag          = inst_addr_i[XLEN-1:3];
   assign unused_addr_lsb = ^inst_addr_i[1:0];
   assign hit     = inst_req_i && buf_v && (buf_tag == pc_tag);
   assign err_hit = inst_req_i && err_v && (err_tag == pc_tag) && !hit;
   assign hit_word = inst_addr_i[2] ? buf_data[XLEN-1:INST_LEN] : buf_data[INST_LEN-1:0];

   assign mem_ar_valid_o = (state == S_AR);
   assign mem_r_ready_o  = (state == S_R);
   assign mem_ar_addr_o  = (state == S_AR) ? {req_tag, 3'b000} : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         buf_v    <= 1'b0;
         buf_tag  <= '0;
         buf_data <= '0;
         err_v    <= 1'b0;
         err_tag  <= '0;
         req_tag  <= '0;
         drop     <= 1'b0;
      end else begin
         state    <= state_nxt;
         buf_v    <= buf_v_nxt;
         buf_tag  <= buf_tag_nxt;
         buf_data <= buf_data_nxt;
         err_v    <= err_v_nxt;
         err_tag  <= err_tag_nxt;
         req_tag  <= req_tag_nxt;
         drop     <= drop_nxt;
      end
   end

   // Fetch-side response: buffer hit wins over the error entry.
   always_comb begin
      if_rdata_valid_o  = 1'b0;
      if_access_fault_o = 1'b0;
      if_rdata_o        = {32'b0, NOP};
      if (hit) begin
         if_rdata_valid_o = 1'b1;
         if_rdata_o       = {32'b0, hit_word};
      end else if (err_hit) begin
         if_rdata_valid_o  = 1'b1;
         if_access_fault_o = 1'b1;
      end
   end

   always_comb begin
      state_nxt    = state;
      buf_v_nxt    = buf_v;
      buf_tag_nxt  = buf_tag;
      buf_data_nxt = buf_data;
      err_v_nxt    = err_v;
      err_tag_nxt  = err_tag;
      req_tag_nxt  = req_tag;
      drop_nxt     = drop;

      if (flush_i) err_v_nxt = 1'b0;

      case (state)
         S_IDLE: begin
            if (inst_req_i && !hit && !err_hit) begin
               state_nxt   = S_AR;
               req_tag_nxt = pc_tag;
               drop_nxt    = 1'b0;
            end
         end
         S_AR: begin
            if (mem_ar_ready_i) state_nxt = S_R;
         end
         S_R: begin
            if (mem_r_valid_i) begin
               state_nxt = S_IDLE;
               if (!drop) begin
                  if (mem_r_resp_i == 2'b00) begin
                     buf_v_nxt    = 1'b1;
                     buf_tag_nxt  = req_tag;
                     buf_data_nxt = mem_r_data_i;
                  end else begin
                     err_v_nxt   = 1'b1;
                     err_tag_nxt = req_tag;
                  end
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      // fence_i overrides any fill landing this cycle and poisons an in-flight beat.
      if (fence_i_i) begin
         buf_v_nxt = 1'b0;
         err_v_nxt = 1'b0;
         if (state != S_IDLE) drop_nxt = 1'b1;
      end
   end

endmodule

// File: tb/tb_ysyx_041514_ifu_responder.sv
// Bench for ysyx_041514_ifu_responder: directed scenarios plus random traffic
// against a memory model whose contents change on every fence_i.
module tb_ysyx_041514_ifu_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] inst_addr_i;
   logic        inst_req_i, flush_i, fence_i_i;
   logic        if_rdata_valid_o, if_access_fault_o;
   logic [63:0] if_rdata_o;
   logic        mem_ar_valid_o, mem_ar_ready_i, mem_r_valid_i, mem_r_ready_o;
   logic [63:0] mem_ar_addr_o, mem_r_data_i;
   logic [1:0]  mem_r_resp_i;

   ysyx_041514_ifu_responder dut (
      .clk(clk), .rst(rst), .inst_addr_i(inst_addr_i), .inst_req_i(inst_req_i),
      .flush_i(flush_i), .fence_i_i(fence_i_i), .if_rdata_valid_o(if_rdata_valid_o),
      .if_rdata_o(if_rdata_o), .if_access_fault_o(if_access_fault_o),
      .mem_ar_valid_o(mem_ar_valid_o), .mem_ar_ready_i(mem_ar_ready_i),
      .mem_ar_addr_o(mem_ar_addr_o), .mem_r_valid_i(mem_r_valid_i),
      .mem_r_ready_o(mem_r_ready_o), .mem_r_data_i(mem_r_data_i), .mem_r_resp_i(mem_r_resp_i));

   always #5 clk = ~clk;

   int unsigned n_vec = 0, n_bad = 0;
   // stimulus requested by the scenario code, applied by step()
   logic        s_rst = 1'b1, s_req = 1'b0, s_flush = 1'b0, s_fence = 1'b0;
   logic [63:0] s_addr = 64'h0;
   // memory / slave model
   int unsigned version = 0;
   int unsigned ar_delay = 0, r_delay = 0, ar_wait = 0, r_wait = 0;
   logic        pending = 1'b0, ar_hs = 1'b0, r_hs = 1'b0;
   logic [63:0] ar_hs_addr = 64'h0, snap = 64'h0;
   logic [1:0]  snap_resp = 2'b0;
   logic        prev_ar_stall = 1'b0;
   logic [63:0] prev_ar_addr = 64'h0;
   int unsigned stall = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic is_err(input logic [63:0] a);
      return a[63:8] == 56'h80_0002;
   endfunction

   // Memory contents; every fence_i models a code rewrite by bumping version.
   function automatic logic [63:0] mem_word(input logic [63:0] a);
      logic [31:0] t;
      if (version == 0 && a[63:3] == 61'(64'h8000_0000 >> 3)) return 64'h00A00093_00100093;
      t = a[34:3];
      return {t * 32'd2654435761 ^ 32'(version), t + 32'h1000 * 32'(version) + 32'h5};
   endfunction

   function automatic logic [63:0] exp_inst(input logic [63:0] a);
      logic [63:0] w;
      w = mem_word(a);
      return a[2] ? {32'b0, w[63:32]} : {32'b0, w[31:0]};
   endfunction

   // One clock: commit handshakes, apply stimulus, run the slave, check invariants.
   task automatic step();
      @(posedge clk);
      if (rst) begin
         pending = 1'b0;
      end else begin
         if (ar_hs) begin
            pending   = 1'b1;
            snap      = mem_word(ar_hs_addr);
            snap_resp = is_err(ar_hs_addr) ? 2'd2 : 2'd0;
            r_wait    = r_delay;
         end
         if (r_hs) pending = 1'b0;
      end
      if (fence_i_i) version++;
      #1;
      rst = s_rst; inst_req_i = s_req; inst_addr_i = s_addr;
      flush_i = s_flush; fence_i_i = s_fence;
      mem_ar_ready_i = 1'b0;
      if (mem_ar_valid_o) begin
         if (ar_wait == 0) mem_ar_ready_i = 1'b1;
         else ar_wait--;
      end else ar_wait = ar_delay;
      mem_r_valid_i = 1'b0;
      if (pending) begin
         if (r_wait == 0) mem_r_valid_i = 1'b1;
         else r_wait--;
      end
      mem_r_data_i = mem_r_valid_i ? snap : {$urandom, $urandom};
      mem_r_resp_i = mem_r_valid_i ? snap_resp : 2'($urandom);
      ar_hs      = mem_ar_valid_o && mem_ar_ready_i;
      ar_hs_addr = mem_ar_addr_o;
      r_hs       = mem_r_ready_o && mem_r_valid_i;
      #1;
      if (!rst) begin
         check("one_channel", 64'(mem_ar_valid_o && mem_r_ready_o), 64'd0);
         if (mem_ar_valid_o) check("ar_align", 64'(mem_ar_addr_o[2:0]), 64'd0);
         if (mem_ar_valid_o && prev_ar_stall) check("ar_stable", mem_ar_addr_o, prev_ar_addr);
         if (!inst_req_i) check("valid_no_req", 64'(if_rdata_valid_o), 64'd0);
         if (if_rdata_valid_o) begin
            check("fault_flag", 64'(if_access_fault_o), 64'(is_err(inst_addr_i)));
            check("rdata", if_rdata_o, if_access_fault_o ? 64'h13 : exp_inst(inst_addr_i));
         end else begin
            check("idle_rdata", if_rdata_o, 64'h13);
            check("idle_fault", 64'(if_access_fault_o), 64'd0);
         end
         if (inst_req_i && !if_rdata_valid_o) stall++; else stall = 0;
         if (stall > 100) begin
            check("stall_bound", 64'(stall), 64'd0);
            stall = 0;
         end
      end
      prev_ar_stall = mem_ar_valid_o && !mem_ar_ready_i;
      prev_ar_addr  = mem_ar_addr_o;
   endtask

   task automatic wait_valid(input int unsigned bound, output int unsigned cycles);
      cycles = 0;
      while (cycles < bound) begin
         step();
         cycles++;
         if (if_rdata_valid_o) return;
      end
      check("wait_valid_timeout", 64'(cycles), 64'(bound + 1));
   endtask

   task automatic drain();
      int unsigned k = 0;
      s_req = 1'b0; s_flush = 1'b0; s_fence = 1'b0;
      step();
      while ((mem_ar_valid_o || mem_r_ready_o || pending) && k < 40) begin
         step();
         k++;
      end
      if (k >= 40) check("drain_timeout", 64'(k), 64'd0);
   endtask

   initial begin
      int unsigned cyc;
      rst = 1'b1; inst_req_i = 1'b0; inst_addr_i = '0; flush_i = 1'b0; fence_i_i = 1'b0;
      mem_ar_ready_i = 1'b0; mem_r_valid_i = 1'b0; mem_r_data_i = '0; mem_r_resp_i = '0;

      // reset values
      s_rst = 1'b1; step(); step();
      check("rst_valid", 64'(if_rdata_valid_o), 64'd0);
      check("rst_rdata", if_rdata_o, 64'h13);
      check("rst_fault", 64'(if_access_fault_o), 64'd0);
      check("rst_ar_valid", 64'(mem_ar_valid_o), 64'd0);
      check("rst_ar_addr", mem_ar_addr_o, 64'd0);
      check("rst_r_ready", 64'(mem_r_ready_o), 64'd0);

      // cold miss, zero-wait slave
      s_rst = 1'b0; s_req = 1'b1; s_addr = 64'h8000_0000;
      step();
      check("cold_n_valid", 64'(if_rdata_valid_o), 64'd0);
      step();
      check("cold_ar_valid", 64'(mem_ar_valid_o), 64'd1);
      check("cold_ar_addr", mem_ar_addr_o, 64'h8000_0000);
      step();
      check("cold_r_ready", 64'(mem_r_ready_o), 64'd1);
      step();
      check("cold_valid", 64'(if_rdata_valid_o), 64'd1);
      check("cold_rdata", if_rdata_o, 64'h0010_0093);
      s_addr = 64'h8000_0004;
      step();
      check("hit_valid", 64'(if_rdata_valid_o), 64'd1);
      check("hit_rdata", if_rdata_o, 64'h00A0_0093);
      check("hit_no_ar", 64'(mem_ar_valid_o), 64'd0);

      // backpressure: 4 AR waits + 3 R waits
      ar_delay = 4; r_delay = 3; s_addr = 64'h8000_0040;
      step();
      wait_valid(30, cyc);
      check("bp_latency", 64'(cyc), 64'd10);
      ar_delay = 0; r_delay = 0;

      // flush plus redirect while in R
      r_delay = 2; s_addr = 64'h8000_0000;
      step(); step();
      s_flush = 1'b1; s_addr = 64'h8000_0100;
      step();
      s_flush = 1'b0;
      step(); step(); step();
      check("flush_idle_valid", 64'(if_rdata_valid_o), 64'd0);
      ar_delay = 2;
      step();
      check("flush_new_ar", 64'(mem_ar_valid_o), 64'd1);
      check("flush_new_ar_addr", mem_ar_addr_o, 64'h8000_0100);
      s_addr = 64'h8000_0000;
      step();
      check("flush_old_fill_hit", 64'(if_rdata_valid_o), 64'd1);
      check("flush_old_fill_data", if_rdata_o, 64'h0010_0093);
      ar_delay = 0; r_delay = 0;
      drain();

      // fence_i during AR
      ar_delay = 2; s_req = 1'b1; s_addr = 64'h8000_0300;
      step(); step();
      s_fence = 1'b1;
      step();
      s_fence = 1'b0; ar_delay = 0;
      cyc = 0;
      while (!r_hs && cyc < 20) begin
         step();
         cyc++;
      end
      step();
      check("fence_nofill", 64'(if_rdata_valid_o), 64'd0);
      step();
      check("fence_reissue_ar", 64'(mem_ar_valid_o), 64'd1);
      check("fence_reissue_addr", mem_ar_addr_o, 64'h8000_0300);
      wait_valid(20, cyc);

      // bus error then flush
      s_addr = 64'h8000_0200;
      step(); step(); step(); step();
      check("err_valid", 64'(if_rdata_valid_o), 64'd1);
      check("err_fault", 64'(if_access_fault_o), 64'd1);
      check("err_rdata", if_rdata_o, 64'h13);
      s_flush = 1'b1;
      step();
      s_flush = 1'b0;
      step();
      check("err_flush_miss", 64'(if_rdata_valid_o), 64'd0);
      step();
      check("err_reissue_ar", 64'(mem_ar_valid_o), 64'd1);
      check("err_reissue_addr", mem_ar_addr_o, 64'h8000_0200);
      drain();

      // reset during R; buffer (holding 0x80000300) must be invalid afterwards
      r_delay = 3; s_req = 1'b1; s_addr = 64'h8000_0400;
      step(); step(); step();
      check("mid_r_state", 64'(mem_r_ready_o), 64'd1);
      s_rst = 1'b1;
      step();
      s_rst = 1'b0; s_addr = 64'h8000_0300;
      step();
      check("mr_valid", 64'(if_rdata_valid_o), 64'd0);
      check("mr_rdata", if_rdata_o, 64'h13);
      check("mr_ar_valid", 64'(mem_ar_valid_o), 64'd0);
      check("mr_ar_addr", mem_ar_addr_o, 64'd0);
      check("mr_r_ready", 64'(mem_r_ready_o), 64'd0);
      r_delay = 0;

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) < 3) begin
            int unsigned idx;
            idx = $urandom_range(0, 9);
            s_addr = (idx < 8) ? 64'h8000_0000 + 64'(idx * 8) : 64'h8000_0200 + 64'((idx - 8) * 8);
            s_addr = s_addr + 64'($urandom_range(0, 1) * 4);
         end
         s_req    = ($urandom_range(0, 9) != 0);
         s_flush  = ($urandom_range(0, 19) == 0);
         s_fence  = ($urandom_range(0, 24) == 0);
         ar_delay = $urandom_range(0, 3);
         r_delay  = $urandom_range(0, 3);
         step();
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
